wlan_interleaver: RTL and testbench

Block interleaver for the 802.11a TX chain, directly downstream of the convolutional encoder (TX_Controller). It consumes the encoder's serial coded-bit stream (oData/oTX, one bit per fast clock) and reorders each OFDM symbol's worth of coded bits per the 802.11a first permutation. For BPSK/QPSK the second permutation is the identity, so it is omitted. It uses a ping-pong pair of symbol buffers so a new symbol can be written while the previous one is read out, sustaining one bit per clock with no stalls.

---
 rtl/wlan_interleaver.sv | 163 ++++++++++++++++
 tb/tb_wlan_interleaver.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wlan_interleaver.sv
// 802.11a block interleaver (first permutation only) with ping-pong symbol banks.
// Coded bits are written in serial order and read out column-wise, one bit per clock.
module wlan_interleaver #(
  parameter int unsigned N_CBPS = 48,
  parameter int unsigned N_COL  = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iData,
  input  logic iValid,
  output logic oData,
  output logic oValid,
  output logic oSymDone
);

  localparam int unsigned N_ROW = N_CBPS / N_COL;
  localparam int unsigned AW    = $clog2(N_CBPS);
  localparam int unsigned RW    = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int unsigned CW    = $clog2(N_COL);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_e;

  // Symbol storage and write-side bookkeeping
  logic [1:0][N_CBPS-1:0] bank_q, bank_d;
  logic [AW-1:0]          wcnt_q, wcnt_d;
  logic                   wsel_q, wsel_d;
  logic [1:0]             full_q, full_d;

  // Read-side FSM and position counters (row = j mod R, col = j / R)
  state_e                 state_q, state_d;
  logic                   rsel_q, rsel_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;

  // Registered outputs
  logic                   odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic                   osymdone_q, osymdone_d;

  // Internal combinational handshakes
  logic                   wr_done;
  logic                   rd_clr;
  logic                   rd_last;
  logic [AW-1:0]          rd_addr;

  assign oData    = odata_q;
  assign oValid   = ovalid_q;
  assign oSymDone = osymdone_q;

  // Source bit index for the current output position: k = col + N_COL*row
  assign rd_addr = AW'(col_q) + AW'(row_q) * AW'(N_COL);
  assign rd_last = (row_q == RW'(N_ROW - 1)) && (col_q == CW'(N_COL - 1));

  // Write side: store accepted bits serially, hand over the bank when it fills
  always_comb begin
    bank_d  = bank_q;
    wcnt_d  = wcnt_q;
    wsel_d  = wsel_q;
    wr_done = 1'b0;
    if (iValid) begin
      bank_d[wsel_q][wcnt_q] = iData;
      if (wcnt_q == AW'(N_CBPS - 1)) begin
        wcnt_d  = '0;
        wsel_d  = ~wsel_q;
        wr_done = 1'b1;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end
  end

  // Read side: IDLE emits bit j=0 itself so the first bit lands one edge after the bank fills
  always_comb begin
    state_d    = state_q;
    rsel_d     = rsel_q;
    row_d      = row_q;
    col_d      = col_q;
    odata_d    = 1'b0;
    ovalid_d   = 1'b0;
    osymdone_d = 1'b0;
    rd_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (full_q[rsel_q]) begin
          odata_d  = bank_q[rsel_q][0];
          ovalid_d = 1'b1;
          row_d    = RW'(1);
          col_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        odata_d  = bank_q[rsel_q][rd_addr];
        ovalid_d = 1'b1;
        if (rd_last) begin
          osymdone_d = 1'b1;
          rd_clr     = 1'b1;
          rsel_d     = ~rsel_q;
          row_d      = '0;
          col_d      = '0;
          state_d    = full_q[~rsel_q] ? S_READ : S_IDLE;
        end else if (row_q == RW'(N_ROW - 1)) begin
          row_d = '0;
          col_d = col_q + CW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full flags: released on the last read, raised when the writer completes a bank
  always_comb begin
    full_d = full_q;
    if (rd_clr) begin
      full_d[rsel_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wsel_q] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      bank_q     <= '0;
      wcnt_q     <= '0;
      wsel_q     <= 1'b0;
      full_q     <= '0;
      rsel_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      odata_q    <= 1'b0;
      ovalid_q   <= 1'b0;
      osymdone_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wcnt_q     <= wcnt_d;
      wsel_q     <= wsel_d;
      full_q     <= full_d;
      rsel_q     <= rsel_d;
      row_q      <= row_d;
      col_q      <= col_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      osymdone_q <= osymdone_d;
    end
  end

endmodule

// File: tb/tb_wlan_interleaver.sv
// Scoreboard bench for wlan_interleaver at N_CBPS=48 and N_CBPS=96.
module tb_wlan_interleaver;

  typedef struct {
    logic d;
    logic done;
  } exp_t;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic d48 = 1'b0, v48 = 1'b0, d96 = 1'b0, v96 = 1'b0;
  logic o_data48, o_valid48, o_symdone48;
  logic o_data96, o_valid96, o_symdone96;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t exp48[$];
  exp_t exp96[$];
  int run48 = 0, lastrun48 = 0, firstval48 = 0, last_in48 = 0;
  int run96 = 0, lastrun96 = 0, firstval96 = 0, last_in96 = 0;
  logic [47:0] syms[5];

  wlan_interleaver #(.N_CBPS(48), .N_COL(16)) dut48 (
    .iClk(iClk), .iRst(iRst), .iData(d48), .iValid(v48),
    .oData(o_data48), .oValid(o_valid48), .oSymDone(o_symdone48)
  );

  wlan_interleaver #(.N_CBPS(96), .N_COL(16)) dut96 (
    .iClk(iClk), .iRst(iRst), .iData(d96), .iValid(v96),
    .oData(o_data96), .oValid(o_valid96), .oSymDone(o_symdone96)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Scoreboard for the 48-bit instance: pop and compare each output bit
  always @(negedge iClk) begin
    exp_t e;
    if (o_valid48 === 1'b1) begin
      if (run48 == 0) firstval48 = cyc;
      run48++;
      tests++;
      if (exp48.size() == 0) begin
        fails++;
        $display("FAIL sb48_extra: oValid=1 with nothing expected at cycle %0d", cyc);
      end else begin
        e = exp48.pop_front();
        if (o_data48 !== e.d || o_symdone48 !== e.done) begin
          fails++;
          $display("FAIL sb48_bit: cycle %0d got data=%b symdone=%b, want data=%b symdone=%b",
                   cyc, o_data48, o_symdone48, e.d, e.done);
        end
      end
    end else begin
      if (run48 > 0) lastrun48 = run48;
      run48 = 0;
      if (o_symdone48 !== 1'b0 || o_data48 !== 1'b0) begin
        fails++;
        $display("FAIL sb48_idle: cycle %0d got data=%b symdone=%b while oValid=%b, want 0/0",
                 cyc, o_data48, o_symdone48, o_valid48);
      end
    end
  end

  // Scoreboard for the 96-bit instance
  always @(negedge iClk) begin
    exp_t e;
    if (o_valid96 === 1'b1) begin
      if (run96 == 0) firstval96 = cyc;
      run96++;
      tests++;
      if (exp96.size() == 0) begin
        fails++;
        $display("FAIL sb96_extra: oValid=1 with nothing expected at cycle %0d", cyc);
      end else begin
        e = exp96.pop_front();
        if (o_data96 !== e.d || o_symdone96 !== e.done) begin
          fails++;
          $display("FAIL sb96_bit: cycle %0d got data=%b symdone=%b, want data=%b symdone=%b",
                   cyc, o_data96, o_symdone96, e.d, e.done);
        end
      end
    end else begin
      if (run96 > 0) lastrun96 = run96;
      run96 = 0;
      if (o_symdone96 !== 1'b0 || o_data96 !== 1'b0) begin
        fails++;
        $display("FAIL sb96_idle: cycle %0d got data=%b symdone=%b while oValid=%b, want 0/0",
                 cyc, o_data96, o_symdone96, o_valid96);
      end
    end
  end

  // Expected output of one 48-bit symbol: out[j] = in[16*(j%3) + j/3]
  task automatic push48(input logic [47:0] b);
    exp_t e;
    for (int j = 0; j < 48; j++) begin
      e.d    = b[16 * (j % 3) + j / 3];
      e.done = (j == 47);
      exp48.push_back(e);
    end
  endtask

  task automatic push96(input logic [95:0] b);
    exp_t e;
    for (int j = 0; j < 96; j++) begin
      e.d    = b[16 * (j % 6) + j / 6];
      e.done = (j == 95);
      exp96.push_back(e);
    end
  endtask

  // Expected output of a single-one symbol via the inverse map j = R*(k%16) + k/16
  task automatic push_onehot(input int n, input int k);
    exp_t e;
    int r;
    r = n / 16;
    for (int j = 0; j < n; j++) begin
      e.d    = (j == r * (k % 16) + k / 16);
      e.done = (j == n - 1);
      if (n == 48) exp48.push_back(e);
      else         exp96.push_back(e);
    end
  endtask

  // Drive the first n bits of a symbol; gap inserts an idle cycle before each odd bit
  task automatic send48(input logic [47:0] b, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      if (gap && (k % 2 == 1)) begin
        v48 = 1'b0;
        d48 = ~b[k];
        @(posedge iClk); #1;
      end
      d48 = b[k];
      v48 = 1'b1;
      @(posedge iClk); #1;
    end
    v48 = 1'b0;
    d48 = 1'b0;
    last_in48 = cyc;
  endtask

  task automatic send96(input logic [95:0] b);
    for (int k = 0; k < 96; k++) begin
      d96 = b[k];
      v96 = 1'b1;
      @(posedge iClk); #1;
    end
    v96 = 1'b0;
    d96 = 1'b0;
    last_in96 = cyc;
  endtask

  // Bounded wait for both scoreboards to empty, plus a few idle cycles
  task automatic drain(output bit ok);
    int n;
    n = 0;
    while ((exp48.size() != 0 || exp96.size() != 0) && n < 500) begin
      @(posedge iClk); #1;
      n++;
    end
    ok = (exp48.size() == 0 && exp96.size() == 0);
    repeat (3) begin
      @(posedge iClk); #1;
    end
  endtask

  task automatic test_reset();
    iRst = 1'b0;
    repeat (3) begin
      @(posedge iClk); #1;
    end
    tests++;
    if ({o_data48, o_valid48, o_symdone48} !== 3'b000) begin
      fails++;
      $display("FAIL reset48: outputs=%b, want 000", {o_data48, o_valid48, o_symdone48});
    end
    tests++;
    if ({o_data96, o_valid96, o_symdone96} !== 3'b000) begin
      fails++;
      $display("FAIL reset96: outputs=%b, want 000", {o_data96, o_valid96, o_symdone96});
    end
    iRst = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_single_hot();
    bit ok;
    push_onehot(48, 1);
    send48(48'h2, 48, 1'b0);
    drain(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_hot_drain: %0d bits still expected, want 0", exp48.size());
    end
    tests++;
    if (firstval48 !== last_in48 + 1) begin
      fails++;
      $display("FAIL single_hot_latency: first oValid cycle %0d, want %0d", firstval48, last_in48 + 1);
    end
    tests++;
    if (lastrun48 !== 48) begin
      fails++;
      $display("FAIL single_hot_len: oValid high %0d cycles, want 48", lastrun48);
    end
  endtask

  task automatic test_walking();
    bit ok;
    logic [47:0] b;
    for (int k = 0; k < 48; k++) begin
      b = 48'h1 << k;
      push_onehot(48, k);
      send48(b, 48, 1'b0);
    end
    drain(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL walking_drain: %0d bits still expected, want 0", exp48.size());
    end
    tests++;
    if (lastrun48 !== 48 * 48) begin
      fails++;
      $display("FAIL walking_run: oValid run %0d cycles, want %0d", lastrun48, 48 * 48);
    end
  endtask

  task automatic test_qpsk();
    bit ok;
    logic [95:0] b;
    push_onehot(96, 17);
    send96(96'h1 << 17);
    drain(ok);
    tests++;
    if (!ok || firstval96 !== last_in96 + 1 || lastrun96 !== 96) begin
      fails++;
      $display("FAIL qpsk_hot: ok=%b first=%0d run=%0d, want ok=1 first=%0d run=96",
               ok, firstval96, lastrun96, last_in96 + 1);
    end
    for (int s = 0; s < 2; s++) begin
      b = {$urandom(), $urandom(), $urandom()};
      push96(b);
      send96(b);
    end
    drain(ok);
    tests++;
    if (!ok || lastrun96 !== 192) begin
      fails++;
      $display("FAIL qpsk_b2b: ok=%b run=%0d, want ok=1 run=192", ok, lastrun96);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int s = 0; s < 5; s++) begin
      syms[s] = 48'({$urandom(), $urandom()});
      push48(syms[s]);
      send48(syms[s], 48, 1'b0);
    end
    drain(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL b2b_drain: %0d bits still expected, want 0", exp48.size());
    end
    tests++;
    if (lastrun48 !== 240) begin
      fails++;
      $display("FAIL b2b_run: oValid run %0d cycles, want 240", lastrun48);
    end
  endtask

  task automatic test_gapped();
    bit ok;
    for (int s = 0; s < 5; s++) begin
      push48(syms[s]);
      send48(syms[s], 48, 1'b1);
    end
    drain(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL gapped_drain: %0d bits still expected, want 0", exp48.size());
    end
    tests++;
    if (firstval48 !== last_in48 + 1 || lastrun48 !== 48) begin
      fails++;
      $display("FAIL gapped_timing: first=%0d run=%0d, want first=%0d run=48",
               firstval48, lastrun48, last_in48 + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [47:0] b;
    b = 48'({$urandom(), $urandom()});
    push48(b);
    send48(b, 48, 1'b0);
    b = 48'({$urandom(), $urandom()});
    send48(b, 20, 1'b0);
    tests++;
    if (o_valid48 !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: oValid=%b before reset, want 1", o_valid48);
    end
    iRst = 1'b0;
    #1;
    tests++;
    if (o_valid48 !== 1'b0 || o_data48 !== 1'b0 || o_symdone48 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: valid=%b data=%b symdone=%b, want 0/0/0",
               o_valid48, o_data48, o_symdone48);
    end
    exp48.delete();
    repeat (2) begin
      @(posedge iClk); #1;
    end
    iRst = 1'b1;
    @(posedge iClk); #1;
    b = 48'({$urandom(), $urandom()});
    push48(b);
    send48(b, 48, 1'b0);
    drain(ok);
    tests++;
    if (!ok || firstval48 !== last_in48 + 1 || lastrun48 !== 48) begin
      fails++;
      $display("FAIL rstmid_after: ok=%b first=%0d run=%0d, want ok=1 first=%0d run=48",
               ok, firstval48, lastrun48, last_in48 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_hot();
    test_walking();
    test_qpsk();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
